// File: rtl/cla_share_arb_if.sv
// Request/response bundle for cla_share_arb: two operand-pair request
// channels (valid/ready) and one tagged response channel (valid/ready).
// slave  : the arbiter side; master : the requester/consumer side.
interface cla_share_arb_if #(
    parameter int N = 8
);
    logic         req0_valid;
    logic         req0_ready;
    logic [N-1:0] req0_a;
    logic [N-1:0] req0_b;
    logic         req1_valid;
    logic         req1_ready;
    logic [N-1:0] req1_a;
    logic [N-1:0] req1_b;
    logic         rsp_valid;
    logic         rsp_ready;
    logic         rsp_id;
    logic [N:0]   rsp_sum;
    logic         rsp_ovf;

    modport slave (
        input  req0_valid, req0_a, req0_b,
        input  req1_valid, req1_a, req1_b,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_sum, rsp_ovf
    );

    modport master (
        output req0_valid, req0_a, req0_b,
        output req1_valid, req1_a, req1_b,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_sum, rsp_ovf
    );
endinterface

// File: rtl/cla_share_arb.sv
// Round-robin arbiter and sequencer sharing one 8-bit carry-lookahead adder
// between two requesters. Result is the exact 9-bit signed sum plus an
// overflow flag (sum outside the 8-bit signed range), tagged with the owner.
// Optional build macro: CLA_SHARE_SATURATE_EN clamps the reported sum to
// +127/-128 whenever the overflow flag is set.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | offering ready to one requester, waiting for an accept
// CALC    | adder fed from op_a/op_b, down-counter timing the settle time
// RESP    | result registered, holding rsp_* until the consumer takes it
module cla_share_arb #(
    parameter int N        = 8,
    parameter int CALC_CYC = 1
) (
    input  logic           clk,
    input  logic           rst,
    cla_share_arb_if.slave bus
);

    generate
        if (N != 8) begin : g_bad_width
            $error("cla_share_arb: N must be 8 to match the 8-bit CLA");
        end
        if (CALC_CYC < 1 || CALC_CYC > 15) begin : g_bad_calc
            $error("cla_share_arb: CALC_CYC must be in 1..15");
        end
    endgenerate

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic [3:0] CNT_LOAD = 4'(CALC_CYC - 1);

    logic [1:0]   state;
    logic         last_grant;
    logic         cur_id;
    logic [N-1:0] op_a;
    logic [N-1:0] op_b;
    logic [3:0]   counter;
    logic         grant0;
    logic         grant1;

    logic [N-1:0] gen;
    logic [N-1:0] prop;
    logic [N:0]   carry;
    logic         term;
    logic [N:0]   sum_s;
    logic         ovf_s;
    logic [N:0]   sum_out;

    // Ready offer: only in IDLE; on a tie the requester that did not win last.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state == ST_IDLE) begin
            if (bus.req0_valid && bus.req1_valid) begin
                grant0 = last_grant;
                grant1 = !last_grant;
            end else if (bus.req0_valid) begin
                grant0 = 1'b1;
            end else if (bus.req1_valid) begin
                grant1 = 1'b1;
            end
        end
    end

    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;

    // Carry-lookahead adder on the latched operands; each carry is the flat
    // sum of generate terms propagated through the bits above them.
    always_comb begin
        gen      = op_a & op_b;
        prop     = op_a ^ op_b;
        carry    = '0;
        term     = 1'b0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j <= i; j++) begin
                term = gen[j];
                for (int k = j + 1; k <= i; k++) begin
                    term = term & prop[k];
                end
                carry[i+1] = carry[i+1] | term;
            end
        end
        // Top bit is the sign-extended column, so the 9-bit result never wraps.
        sum_s = {op_a[N-1] ^ op_b[N-1] ^ carry[N], prop ^ carry[N-1:0]};
        ovf_s = sum_s[N] ^ sum_s[N-1];
    end

    // Reported sum: exact, or clamped to the 8-bit range on overflow.
    always_comb begin
`ifdef CLA_SHARE_SATURATE_EN
        if (ovf_s) begin
            sum_out = sum_s[N] ? {2'b11, {(N-1){1'b0}}} : {2'b00, {(N-1){1'b1}}};
        end else begin
            sum_out = sum_s;
        end
`else
        sum_out = sum_s;
`endif
    end

    // Sequencer: accept, time the adder settle, register and hold the result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            last_grant    <= 1'b1;
            cur_id        <= 1'b0;
            op_a          <= '0;
            op_b          <= '0;
            counter       <= '0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_id    <= 1'b0;
            bus.rsp_sum   <= '0;
            bus.rsp_ovf   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant0) begin
                        op_a       <= bus.req0_a;
                        op_b       <= bus.req0_b;
                        cur_id     <= 1'b0;
                        last_grant <= 1'b0;
                        counter    <= CNT_LOAD;
                        state      <= ST_CALC;
                    end else if (grant1) begin
                        op_a       <= bus.req1_a;
                        op_b       <= bus.req1_b;
                        cur_id     <= 1'b1;
                        last_grant <= 1'b1;
                        counter    <= CNT_LOAD;
                        state      <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    if (counter == 4'd0) begin
                        bus.rsp_sum   <= sum_out;
                        bus.rsp_ovf   <= ovf_s;
                        bus.rsp_id    <= cur_id;
                        bus.rsp_valid <= 1'b1;
                        state         <= ST_RESP;
                    end else begin
                        counter <= counter - 4'd1;
                    end
                end
                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        state         <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
